// File: rtl/pipe_stage_skidbuf.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Outputs come from registers only; flush empties the stage and drives a NOP downstream.
module pipe_stage_skidbuf #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 64,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               in_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  input  logic               flush,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   flush_count,
  output logic [CNT_W-1:0]   stall_count
);

  // state | meaning
  // EMPTY | nothing held, in_ready=1, out_valid=0
  // ONE   | main entry valid, in_ready=1
  // TWO   | main and skid valid, in_ready=0
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] main_instr, main_instr_nxt;
  logic [INSTR_W-1:0] skid_instr, skid_instr_nxt;
  logic [PC_W-1:0]    main_pc, main_pc_nxt;
  logic [PC_W-1:0]    skid_pc, skid_pc_nxt;
  logic               ready_q;
  logic               take_in;
  logic               stall_cyc;

  assign take_in   = in_valid & ready_q;
  assign stall_cyc = out_valid & ~out_ready & ~flush;

  always_comb begin
    state_nxt      = state;
    main_instr_nxt = main_instr;
    main_pc_nxt    = main_pc;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;
    case (state)
      EMPTY: begin
        if (take_in) begin
          main_instr_nxt = in_instr;
          main_pc_nxt    = in_pc;
          state_nxt      = ONE;
        end
      end
      ONE: begin
        if (out_ready) begin
          if (take_in) begin
            main_instr_nxt = in_instr;
            main_pc_nxt    = in_pc;
          end else begin
            state_nxt = EMPTY;
          end
        end else if (take_in) begin
          skid_instr_nxt = in_instr;
          skid_pc_nxt    = in_pc;
          state_nxt      = TWO;
        end
      end
      TWO: begin
        if (out_ready) begin
          main_instr_nxt = skid_instr;
          main_pc_nxt    = skid_pc;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // entries are invalidated purely by the state going EMPTY
    if (flush) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      ready_q     <= 1'b1;
      main_instr  <= NOP_INSTR;
      main_pc     <= '0;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= '0;
      flush_count <= '0;
      stall_count <= '0;
    end else begin
      state      <= state_nxt;
      ready_q    <= (state_nxt != TWO);
      main_instr <= main_instr_nxt;
      main_pc    <= main_pc_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc    <= skid_pc_nxt;
      if (flush && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
      if (stall_cyc && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_instr = out_valid ? main_instr : NOP_INSTR;
  assign out_pc    = out_valid ? main_pc : '0;
  assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_skidbuf.sv
// Directed bench for pipe_stage_skidbuf: vector table for handshake/flush/reset,
// plus a CNT_W=4 instance for counter saturation.
module tb_pipe_stage_skidbuf;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        in_ready, out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [1:0]  occupancy;
  logic [15:0] flush_count, stall_count;

  logic        s_reset, s_flush, s_in_valid, s_out_ready;
  logic [31:0] s_in_instr;
  logic [63:0] s_in_pc;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_instr;
  logic [63:0] s_out_pc;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_flush_count, s_stall_count;

  pipe_stage_skidbuf dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .flush(flush), .occupancy(occupancy),
    .flush_count(flush_count), .stall_count(stall_count)
  );

  pipe_stage_skidbuf #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_instr(s_in_instr), .in_pc(s_in_pc),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_instr(s_out_instr), .out_pc(s_out_pc),
    .out_ready(s_out_ready), .flush(s_flush), .occupancy(s_occupancy),
    .flush_count(s_flush_count), .stall_count(s_stall_count)
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic        e_ir;
    logic [1:0]  e_occ;
    logic [15:0] e_fc;
    logic [15:0] e_sc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  localparam logic [31:0] NOP = 32'h00000013;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [31:0] instr,
                     input logic [63:0] pc, input logic ordy, input logic e_ov,
                     input logic [31:0] e_instr, input logic [63:0] e_pc, input logic e_ir,
                     input logic [1:0] e_occ, input logic [15:0] e_fc, input logic [15:0] e_sc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.instr = instr; v.pc = pc; v.ordy = ordy;
    v.e_ov = e_ov; v.e_instr = e_instr; v.e_pc = e_pc; v.e_ir = e_ir;
    v.e_occ = e_occ; v.e_fc = e_fc; v.e_sc = e_sc;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    s_reset = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_in_instr = '0; s_in_pc = '0;
    s_out_ready = 1'b1;

    //   rst fl iv instr     pc         ordy | ov instr    pc        ir occ fc sc
    add(1, 0, 0, 32'h0,  64'h0,    1,  0, NOP,     64'h0,    1, 0, 0, 0); // reset
    add(0, 0, 0, 32'h0,  64'h0,    1,  0, NOP,     64'h0,    1, 0, 0, 0); // idle
    add(0, 0, 1, 32'hA0, 64'h1000, 1,  1, 32'hA0,  64'h1000, 1, 1, 0, 0); // streaming
    add(0, 0, 1, 32'hA1, 64'h1004, 1,  1, 32'hA1,  64'h1004, 1, 1, 0, 0);
    add(0, 0, 1, 32'hA2, 64'h1008, 1,  1, 32'hA2,  64'h1008, 1, 1, 0, 0);
    add(0, 0, 1, 32'hA3, 64'h100C, 1,  1, 32'hA3,  64'h100C, 1, 1, 0, 0);
    add(0, 0, 0, 32'h0,  64'h0,    1,  0, NOP,     64'h0,    1, 0, 0, 0);
    add(0, 0, 1, 32'hB0, 64'h2000, 1,  1, 32'hB0,  64'h2000, 1, 1, 0, 0); // back-pressure
    add(0, 0, 1, 32'hB1, 64'h2004, 0,  1, 32'hB0,  64'h2000, 0, 2, 0, 1);
    add(0, 0, 1, 32'hB2, 64'h2008, 0,  1, 32'hB0,  64'h2000, 0, 2, 0, 2);
    add(0, 0, 1, 32'hB2, 64'h2008, 0,  1, 32'hB0,  64'h2000, 0, 2, 0, 3);
    add(0, 0, 1, 32'hB2, 64'h2008, 1,  1, 32'hB1,  64'h2004, 1, 1, 0, 3);
    add(0, 0, 1, 32'hB2, 64'h2008, 1,  1, 32'hB2,  64'h2008, 1, 1, 0, 3);
    add(0, 0, 0, 32'h0,  64'h0,    1,  0, NOP,     64'h0,    1, 0, 0, 3);
    add(0, 0, 1, 32'hC0, 64'h3000, 1,  1, 32'hC0,  64'h3000, 1, 1, 0, 3); // flush at occ=2
    add(0, 0, 1, 32'hC1, 64'h3004, 0,  1, 32'hC0,  64'h3000, 0, 2, 0, 4);
    add(0, 1, 1, 32'hC2, 64'h3008, 0,  0, NOP,     64'h0,    1, 0, 1, 4);
    add(0, 0, 0, 32'h0,  64'h0,    1,  0, NOP,     64'h0,    1, 0, 1, 4);
    add(0, 1, 1, 32'hD0, 64'h3100, 1,  0, NOP,     64'h0,    1, 0, 2, 4); // flush drops input
    add(0, 0, 0, 32'h0,  64'h0,    1,  0, NOP,     64'h0,    1, 0, 2, 4);
    add(1, 1, 1, 32'hD1, 64'h3200, 1,  0, NOP,     64'h0,    1, 0, 0, 0); // reset+flush
    add(0, 0, 1, 32'hE0, 64'h4000, 0,  1, 32'hE0,  64'h4000, 1, 1, 0, 0); // reset at occ=2
    add(0, 0, 1, 32'hE1, 64'h4004, 0,  1, 32'hE0,  64'h4000, 0, 2, 0, 1);
    add(1, 0, 1, 32'hE2, 64'h4008, 0,  0, NOP,     64'h0,    1, 0, 0, 0);
    add(0, 0, 1, 32'hF0, 64'h5000, 1,  1, 32'hF0,  64'h5000, 1, 1, 0, 0);
    add(0, 0, 0, 32'h0,  64'h0,    1,  0, NOP,     64'h0,    1, 0, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; flush = vecs[i].fl; in_valid = vecs[i].iv;
      in_instr = vecs[i].instr; in_pc = vecs[i].pc; out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("v%0d out_instr", i), 64'(out_instr), 64'(vecs[i].e_instr));
      chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].e_pc);
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
      chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(vecs[i].e_occ));
      chk($sformatf("v%0d flush_count", i), 64'(flush_count), 64'(vecs[i].e_fc));
      chk($sformatf("v%0d stall_count", i), 64'(stall_count), 64'(vecs[i].e_sc));
    end

    // counter saturation on the CNT_W=4 instance
    @(posedge clk); #1;
    s_reset = 1'b0; s_in_valid = 1'b1; s_in_instr = 32'h55; s_in_pc = 64'h6000;
    @(posedge clk); #1;
    chk("sat loaded", 64'(s_out_instr), 64'h55);
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 14) chk("stall 14", 64'(s_stall_count), 64'd14);
      if (c == 15) chk("stall 15", 64'(s_stall_count), 64'd15);
    end
    chk("stall saturated", 64'(s_stall_count), 64'd15);
    chk("sat still valid", 64'(s_out_valid), 64'd1);
    s_flush = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
    end
    chk("flush saturated", 64'(s_flush_count), 64'd15);
    chk("stall held", 64'(s_stall_count), 64'd15);
    chk("sat flushed occ", 64'(s_occupancy), 64'd0);
    s_flush = 1'b0;
    @(posedge clk); #1;
    chk("flush held", 64'(s_flush_count), 64'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
